// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, converter state type and decimal helpers for the 7-seg display path
// Contents: BCD_DIGIT_W, SEG_OFF, conv_state_e, pow10(), ovf_threshold()
package seg7_pkg;
   localparam int BCD_DIGIT_W = 4;
   localparam logic [6:0] SEG_OFF = 7'b1111111;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;
   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction
   // smallest binary value that no longer fits in the given number of BCD digits
   function automatic longint unsigned ovf_threshold(input int digits);
      return pow10(digits);
   endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to a BCD digit of 5 or more
// Ports: din  - working BCD digit before the shift
//        dout - corrected digit, ready to be shifted left
module bcd_digit_adj
   import seg7_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] din,
   output logic [BCD_DIGIT_W-1:0] dout
);
   always_comb dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter, one double-dabble step per clock
// Ports: clk, rst (async, active-high)
//        start/bin  - conversion request and value, accepted in IDLE or DONE
//        busy       - conversion in progress
//        done       - one-cycle pulse when bcd/overflow are updated
//        bcd        - packed digits, digit 0 least significant, held until next done
//        overflow   - captured bin >= 10^DIGITS (bcd then holds bin mod 10^DIGITS)
//        blank      - leading-zero blanking mask, only when BIN2BCD_BLANK_EN is defined
module bin2bcd_seq
   import seg7_pkg::*;
#(
   parameter int W      = 16,
   parameter int DIGITS = 5
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [W-1:0]                  bin,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic                          overflow
`ifdef BIN2BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]             blank
`endif
);
   localparam int BW = BCD_DIGIT_W * DIGITS;
   localparam int CW = $clog2(W + 1);
   conv_state_e state_q, state_d;
   logic [W-1:0] shreg_q, shreg_d;
   logic [BW-1:0] work_q, work_d, work_nx, adj, bcd_q, bcd_d;
   logic [CW-1:0] count_q, count_d;
   logic carry_q, carry_d, carry_nx;
   logic busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   logic last, accept;
   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (work_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
         .dout (adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
      );
   end
   always_comb begin
      work_nx  = {adj[BW-2:0], shreg_q[W-1]};
      // any 1 leaving the top digit means the value no longer fits
      carry_nx = carry_q | adj[BW-1];
      last     = (state_q == SHIFT) && (count_q == CW'(1));
      accept   = start && (state_q != SHIFT);
      state_d  = (state_q == SHIFT) ? (last ? DONE : SHIFT) : accept ? SHIFT : IDLE;
      shreg_d  = (state_q == SHIFT) ? {shreg_q[W-2:0], 1'b0} : accept ? bin : shreg_q;
      work_d   = (state_q == SHIFT) ? work_nx : accept ? '0 : work_q;
      carry_d  = (state_q == SHIFT) ? carry_nx : accept ? 1'b0 : carry_q;
      count_d  = (state_q == SHIFT) ? count_q - 1'b1 : accept ? CW'(W) : count_q;
      busy_d   = (state_d == SHIFT);
      done_d   = last;
      bcd_d    = last ? work_nx : bcd_q;
      ovf_d    = last ? carry_nx : ovf_q;
   end
`ifdef BIN2BCD_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d, blank_nx;
   logic all_zero;
   always_comb begin
      all_zero = 1'b1;
      blank_nx = '0;
      // digit 0 is never blanked so zero still shows a single "0"
      for (int i = DIGITS - 1; i >= 1; i--) begin
         all_zero    = all_zero & (work_nx[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
         blank_nx[i] = all_zero;
      end
      blank_d = last ? blank_nx : blank_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) blank_q <= '0;
      else     blank_q <= blank_d;
   assign blank = blank_q;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         work_q  <= '0;
         count_q <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         work_q  <= work_d;
         count_q <= count_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end
   assign busy     = busy_q;
   assign done     = done_q;
   assign bcd      = bcd_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: self-checking bench for bin2bcd_seq with 5-digit and 4-digit instances in lockstep
// Optional: define BIN2BCD_BLANK_EN to also check the blank outputs
module tb_bin2bcd_seq;
   import seg7_pkg::*;
   localparam int W = 16;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [W-1:0] bin = '0;
   logic busy5, done5, ovf5, busy4, done4, ovf4;
   logic [19:0] bcd5, exp5;
   logic [15:0] bcd4, exp4;
   logic eo5, eo4;
   logic [4:0] eb5;
   logic [3:0] eb4;
`ifdef BIN2BCD_BLANK_EN
   logic [4:0] blank5;
   logic [3:0] blank4;
`endif
   int n_vec = 0, n_err = 0;
   always #5 clk = ~clk;
   bin2bcd_seq #(.W(W), .DIGITS(5)) u_dut5 (
      .clk(clk), .rst(rst), .start(start), .bin(bin),
      .busy(busy5), .done(done5), .bcd(bcd5), .overflow(ovf5)
`ifdef BIN2BCD_BLANK_EN
      , .blank(blank5)
`endif
   );
   bin2bcd_seq #(.W(W), .DIGITS(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start), .bin(bin),
      .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ovf4)
`ifdef BIN2BCD_BLANK_EN
      , .blank(blank4)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] ref_bcd(input longint unsigned v, input int d);
      longint unsigned x;
      logic [31:0] r;
      x = v % ovf_threshold(d);
      r = '0;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction
   function automatic logic [7:0] ref_blank(input longint unsigned v, input int d);
      longint unsigned x;
      logic [7:0] r;
      x = v % ovf_threshold(d);
      r = '0;
      for (int i = 1; i < d; i++) r[i] = (x / pow10(i)) == 0;
      return r;
   endfunction
   task automatic set_exp(input logic [W-1:0] v);
      exp5 = 20'(ref_bcd(v, 5));
      exp4 = 16'(ref_bcd(v, 4));
      eo5  = longint'(v) >= ovf_threshold(5);
      eo4  = longint'(v) >= ovf_threshold(4);
      eb5  = 5'(ref_blank(v, 5));
      eb4  = 4'(ref_blank(v, 4));
   endtask
   task automatic chk_res(input string tag);
      chk({tag, "_bcd5"}, bcd5, exp5);
      chk({tag, "_bcd4"}, bcd4, exp4);
      chk({tag, "_ovf"}, {ovf5, ovf4}, {eo5, eo4});
`ifdef BIN2BCD_BLANK_EN
      chk({tag, "_blank5"}, blank5, eb5);
      chk({tag, "_blank4"}, blank4, eb4);
`endif
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         tick;
         chk("idle_busy", {busy5, busy4}, 2'b00);
         chk("idle_done", {done5, done4}, 2'b00);
         chk_res("idle");
      end
   endtask
   task automatic conv(input logic [W-1:0] v, input bit noise);
      start = 1'b1;
      bin   = v;
      tick;
      start = 1'b0;
      bin   = W'($urandom);
      for (int c = 1; c <= W; c++) begin
         chk("busy", {busy5, busy4}, 2'b11);
         chk("early_done", {done5, done4}, 2'b00);
         chk_res("hold");
         start = noise && c >= 3 && c <= 10;
         bin   = noise ? W'(1) : W'($urandom);
         tick;
      end
      start = 1'b0;
      set_exp(v);
      chk("done", {done5, done4}, 2'b11);
      chk("done_busy", {busy5, busy4}, 2'b00);
      chk_res("result");
   endtask
   initial begin
      set_exp('0);
      #1;
      chk("rst_busy", {busy5, busy4}, 2'b00);
      chk("rst_done", {done5, done4}, 2'b00);
      chk_res("rst");
      tick;
      rst = 1'b0;
      idle(2);
      conv(16'd0, 1'b0);
      idle(2);
      conv(16'd12345, 1'b0);
      conv(16'd65535, 1'b0);
      idle(1);
      conv(16'd999, 1'b1);
      idle(4);
      start = 1'b1;
      bin   = 16'd4321;
      tick;
      start = 1'b0;
      repeat (7) tick;
      rst = 1'b1;
      #1;
      set_exp('0);
      chk("abort_busy", {busy5, busy4}, 2'b00);
      chk("abort_done", {done5, done4}, 2'b00);
      chk_res("abort");
      tick;
      rst = 1'b0;
      idle(3);
      conv(16'd7, 1'b0);
      idle(1);
      conv(16'd10000, 1'b0);
      conv(16'd12345, 1'b0);
      conv(16'd9999, 1'b0);
      conv(16'd42, 1'b0);
      conv(16'd99, 1'b0);
      for (int t = 0; t < 30; t++) begin
         conv(W'($urandom), 1'($urandom_range(0, 1)));
         idle(int'($urandom_range(0, 2)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
